// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared game-flow types and default timing constants
package tetris_pkg;

  localparam int CLK_HZ          = 50_000_000;
  localparam int SOFT_PERIOD_DEF = CLK_HZ / 50;
  localparam int LOCK_CYCLES_DEF = CLK_HZ / 10;
  localparam int MAX_RESETS_DEF  = 15;
  localparam int CNT_W_DEF       = 24;

  typedef enum logic [2:0] {IDLE, FALL, REQ, HGAP, LOCK_DELAY, LOCK} state_t;
  typedef enum logic [1:0] {GRAV, SOFT, HARD} src_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/drop_timer.sv
// rtl/drop_timer.sv - up-counter with clear, enable and terminal-count flag
module drop_timer
  import tetris_pkg::*;
#(
  parameter int W    = CNT_W_DEF,
  parameter int TERM = SOFT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == W'(TERM - 1));

endmodule

// File: rtl/drop_sequencer.sv
// rtl/drop_sequencer.sv - gravity/soft/hard drop sequencing with lock delay
module drop_sequencer
  import tetris_pkg::*;
#(
  parameter int SOFT_PERIOD = SOFT_PERIOD_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int MAX_RESETS  = MAX_RESETS_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       spawn_valid,
  input  logic       tick,
  input  logic       soft_drop,
  input  logic       hard_drop,
  input  logic       moved,
  input  logic       down_ack,
  input  logic       down_blocked,
  input  logic       lock_ack,
  output logic       down_req,
  output logic       lock_req,
  output logic       active,
  output logic [7:0] drop_count
);

  localparam int RC_W = (MAX_RESETS < 1) ? 1 : $clog2(MAX_RESETS + 1);

  state_t          state, nxt;
  src_t            src, src_nxt;
  logic            probe, probe_nxt;
  logic [RC_W-1:0] resets;
  logic            soft_done, lock_done;
  logic            soft_fire, lock_expire, moved_ok, ack_ok, spawn_entry;

  assign soft_fire   = (state == FALL) && soft_drop && !pause && soft_done;
  assign lock_expire = (state == LOCK_DELAY) && !pause && lock_done;
  // moved is lowest priority in LOCK_DELAY, so any stronger event masks it
  assign moved_ok    = (state == LOCK_DELAY) && !pause && moved && !hard_drop &&
                       !lock_done && !tick && (resets < RC_W'(MAX_RESETS));
  assign ack_ok      = down_ack && !down_blocked;
  assign spawn_entry = (state == IDLE) && (nxt == FALL);

  drop_timer #(.W(CNT_W), .TERM(SOFT_PERIOD)) u_soft (
    .clk  (clk),
    .rst  (rst),
    .clr  (!pause && ((state != FALL) || !soft_drop || soft_fire)),
    .en   ((state == FALL) && soft_drop && !pause),
    .done (soft_done)
  );

  // Held at zero outside LOCK_DELAY/probe so every fresh grounding starts from 0
  drop_timer #(.W(CNT_W), .TERM(LOCK_CYCLES)) u_lock (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state == IDLE) || (state == FALL) || moved_ok),
    .en   ((state == LOCK_DELAY) && !pause),
    .done (lock_done)
  );

  always_comb begin
    nxt       = state;
    src_nxt   = src;
    probe_nxt = probe;
    case (state)
      IDLE: if (spawn_valid && !pause) nxt = FALL;
      FALL: begin
        if (!pause) begin
          if (hard_drop) begin
            nxt = REQ; src_nxt = HARD; probe_nxt = 1'b0;
          end else if (tick) begin
            nxt = REQ; src_nxt = GRAV; probe_nxt = 1'b0;
          end else if (soft_fire) begin
            nxt = REQ; src_nxt = SOFT; probe_nxt = 1'b0;
          end
        end
      end
      // responses are honoured even while paused
      REQ: begin
        if (down_blocked) begin
          probe_nxt = 1'b0;
          nxt       = (src == HARD) ? LOCK : LOCK_DELAY;
        end else if (down_ack) begin
          probe_nxt = 1'b0;
          nxt       = (src == HARD) ? HGAP : FALL;
        end
      end
      HGAP: if (!pause) nxt = REQ;
      LOCK_DELAY: begin
        if (!pause) begin
          if (hard_drop || lock_done) begin
            nxt = LOCK;
          end else if (tick) begin
            nxt = REQ; src_nxt = GRAV; probe_nxt = 1'b1;
          end
        end
      end
      LOCK: if (lock_ack) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src        <= GRAV;
      probe      <= 1'b0;
      resets     <= '0;
      drop_count <= '0;
      down_req   <= 1'b0;
      lock_req   <= 1'b0;
      active     <= 1'b0;
    end else begin
      state    <= nxt;
      src      <= src_nxt;
      probe    <= probe_nxt;
      down_req <= (nxt == REQ);
      lock_req <= (nxt == LOCK);
      active   <= (nxt != IDLE);
      if (spawn_entry) begin
        resets <= '0;
      end else if (moved_ok) begin
        resets <= resets + 1'b1;
      end
      if (spawn_entry) begin
        drop_count <= '0;
      end else if ((state == REQ) && ack_ok && (src != GRAV)) begin
        drop_count <= sat_inc8(drop_count);
      end
    end
  end

  logic unused_expire;
  assign unused_expire = lock_expire;

endmodule

// File: tb/tb_drop_sequencer.sv
// tb/tb_drop_sequencer.sv - randomized scenario bench with timing reference model
module tb_drop_sequencer;

  localparam int SP = 4;
  localparam int LC = 8;
  localparam int MR = 2;

  logic clk, rst, pause, spawn_valid, tick, soft_drop, hard_drop, moved;
  logic down_ack, down_blocked, lock_ack;
  logic down_req, lock_req, active;
  logic [7:0] drop_count;

  int checks = 0;
  int fails  = 0;

  drop_sequencer #(.SOFT_PERIOD(SP), .LOCK_CYCLES(LC), .MAX_RESETS(MR), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .pause(pause), .spawn_valid(spawn_valid), .tick(tick),
    .soft_drop(soft_drop), .hard_drop(hard_drop), .moved(moved), .down_ack(down_ack),
    .down_blocked(down_blocked), .lock_ack(lock_ack), .down_req(down_req),
    .lock_req(lock_req), .active(active), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spawn();
    spawn_valid = 1'b1; step(); spawn_valid = 1'b0;
  endtask

  task automatic enter_ld();
    tick = 1'b1; step(); tick = 1'b0;
    down_blocked = 1'b1; step(); down_blocked = 1'b0;
  endtask

  task automatic finish_lock();
    lock_ack = 1'b1; step(); lock_ack = 1'b0;
  endtask

  // Edges until the selected request is seen high, or -1 when the budget runs out
  task automatic wait_rise(input bit lock_sel, input int budget, output int n);
    int i = 0;
    n = -1;
    while (n < 0 && i < budget) begin
      i++;
      step();
      if ((lock_sel ? lock_req : down_req) === 1'b1) n = i;
    end
  endtask

  task automatic test_reset();
    bit bad = 1'b0;
    rst = 1'b1; step(); step(); rst = 1'b0;
    checks++; if (down_req !== 1'b0) begin fails++; $display("FAIL reset_down_req: got %b expected 0", down_req); end
    checks++; if (lock_req !== 1'b0) begin fails++; $display("FAIL reset_lock_req: got %b expected 0", lock_req); end
    checks++; if (active !== 1'b0) begin fails++; $display("FAIL reset_active: got %b expected 0", active); end
    checks++; if (drop_count !== 8'd0) begin fails++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
    for (int i = 0; i < 6; i++) begin
      tick = 1'($urandom_range(0, 1)); hard_drop = 1'($urandom_range(0, 1));
      step();
      if (down_req !== 1'b0 || active !== 1'b0) bad = 1'b1;
    end
    tick = 1'b0; hard_drop = 1'b0;
    checks++; if (bad !== 1'b0) begin fails++; $display("FAIL idle_ignores_triggers: got activity expected none"); end
  endtask

  task automatic test_gravity();
    bit bad = 1'b0;
    int d;
    spawn();
    checks++; if (active !== 1'b1 || down_req !== 1'b0) begin fails++; $display("FAIL spawn_state: got active=%b down_req=%b expected 1/0", active, down_req); end
    repeat ($urandom_range(0, 5)) step();
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (down_req !== 1'b1) begin fails++; $display("FAIL grav_req: got %b expected 1", down_req); end
    d = $urandom_range(1, 3);
    repeat (d) begin
      tick = 1'($urandom_range(0, 1));
      step();
      if (down_req !== 1'b1) bad = 1'b1;
    end
    tick = 1'b0;
    checks++; if (bad !== 1'b0) begin fails++; $display("FAIL grav_req_hold: got drop expected held high"); end
    down_ack = 1'b1; step(); down_ack = 1'b0;
    checks++; if (down_req !== 1'b0 || drop_count !== 8'd0 || active !== 1'b1) begin
      fails++; $display("FAIL grav_ack: got down_req=%b drop_count=%0d active=%b expected 0/0/1", down_req, drop_count, active);
    end
    bad = 1'b0;
    repeat (3) begin step(); if (down_req !== 1'b0) bad = 1'b1; end
    checks++; if (bad !== 1'b0) begin fails++; $display("FAIL no_tick_queue: got down_req expected none"); end
  endtask

  task automatic test_soft();
    int n, d;
    bit bad = 1'b0;
    soft_drop = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_rise(1'b0, 40, n);
      checks++; if (n !== SP) begin fails++; $display("FAIL soft_interval[%0d]: got %0d expected %0d", r, n, SP); end
      d = $urandom_range(0, 2);
      repeat (d) step();
      if (r == 2) soft_drop = 1'b0;
      down_ack = 1'b1; step(); down_ack = 1'b0;
    end
    checks++; if (drop_count !== 8'd3) begin fails++; $display("FAIL soft_drop_count: got %0d expected 3", drop_count); end
    repeat (3 * SP) begin step(); if (down_req !== 1'b0) bad = 1'b1; end
    checks++; if (bad !== 1'b0) begin fails++; $display("FAIL soft_release: got down_req expected none"); end
  endtask

  task automatic test_hard();
    int n_acks;
    int exp_cnt;
    bit bad = 1'b0;
    exp_cnt = 3;
    hard_drop = 1'b1; step(); hard_drop = 1'b0;
    checks++; if (down_req !== 1'b1) begin fails++; $display("FAIL hard_req: got %b expected 1", down_req); end
    n_acks = $urandom_range(2, 6);
    for (int i = 0; i < n_acks; i++) begin
      down_ack = 1'b1; step(); down_ack = 1'b0;
      if (down_req !== 1'b0) bad = 1'b1;
      step();
      if (down_req !== 1'b1) bad = 1'b1;
    end
    exp_cnt += n_acks;
    checks++; if (bad !== 1'b0) begin fails++; $display("FAIL hard_gap_pattern: got irregular down_req expected 1-cycle gaps"); end
    // simultaneous ack and blocked: blocked must win and not count a row
    down_ack = 1'b1; down_blocked = 1'b1; step(); down_ack = 1'b0; down_blocked = 1'b0;
    checks++; if (lock_req !== 1'b1 || down_req !== 1'b0) begin fails++; $display("FAIL hard_lock: got lock_req=%b down_req=%b expected 1/0", lock_req, down_req); end
    checks++; if (drop_count !== 8'(exp_cnt)) begin fails++; $display("FAIL hard_drop_count: got %0d expected %0d", drop_count, exp_cnt); end
    bad = 1'b0;
    repeat ($urandom_range(0, 3)) begin step(); if (lock_req !== 1'b1) bad = 1'b1; end
    checks++; if (bad !== 1'b0) begin fails++; $display("FAIL lock_req_hold: got drop expected held high"); end
    finish_lock();
    checks++; if (active !== 1'b0 || lock_req !== 1'b0 || drop_count !== 8'(exp_cnt)) begin
      fails++; $display("FAIL lock_done: got active=%b lock_req=%b drop_count=%0d expected 0/0/%0d", active, lock_req, drop_count, exp_cnt);
    end
    spawn();
    checks++; if (drop_count !== 8'd0) begin fails++; $display("FAIL spawn_clears_count: got %0d expected 0", drop_count); end
  endtask

  task automatic test_lock_delay();
    int n, p, elapsed, expected;
    bit bad = 1'b0;
    enter_ld();
    wait_rise(1'b1, 40, n);
    checks++; if (n !== LC) begin fails++; $display("FAIL lock_delay_plain: got %0d expected %0d", n, LC); end
    finish_lock(); spawn(); enter_ld();
    elapsed = 0;
    expected = LC;
    for (int k = 0; k < MR + 1; k++) begin
      p = $urandom_range(0, LC - 2);
      repeat (p) step();
      moved = 1'b1; step(); moved = 1'b0;
      elapsed += p + 1;
      if (k < MR) expected = elapsed + LC;
    end
    wait_rise(1'b1, 60, n);
    checks++; if (n < 0 || elapsed + n !== expected) begin fails++; $display("FAIL lock_delay_moves: got %0d expected %0d", (n < 0) ? -1 : elapsed + n, expected); end
    finish_lock(); spawn(); enter_ld();
    repeat ($urandom_range(0, 5)) step();
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (down_req !== 1'b1) begin fails++; $display("FAIL probe_req: got %b expected 1", down_req); end
    down_ack = 1'b1; step(); down_ack = 1'b0;
    repeat (LC + 4) begin step(); if (lock_req !== 1'b0 || down_req !== 1'b0 || active !== 1'b1) bad = 1'b1; end
    checks++; if (bad !== 1'b0) begin fails++; $display("FAIL probe_ack_falls: got lock or request expected quiet FALL"); end
    enter_ld();
    wait_rise(1'b1, 40, n);
    checks++; if (n !== LC) begin fails++; $display("FAIL lock_after_probe: got %0d expected %0d", n, LC); end
    finish_lock();
  endtask

  task automatic test_pause();
    int n;
    bit bad = 1'b0;
    spawn(); enter_ld();
    repeat (3) step();
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick = 1'($urandom_range(0, 1)); moved = 1'($urandom_range(0, 1)); hard_drop = 1'($urandom_range(0, 1));
      step();
      if (down_req !== 1'b0 || lock_req !== 1'b0) bad = 1'b1;
    end
    tick = 1'b0; moved = 1'b0; hard_drop = 1'b0; pause = 1'b0;
    checks++; if (bad !== 1'b0) begin fails++; $display("FAIL pause_quiet: got request expected none"); end
    wait_rise(1'b1, 40, n);
    checks++; if (n !== LC - 3) begin fails++; $display("FAIL pause_resume_lock: got %0d expected %0d", n, LC - 3); end
    finish_lock(); spawn();
    tick = 1'b1; step(); tick = 1'b0;
    pause = 1'b1;
    bad = 1'b0;
    repeat ($urandom_range(1, 4)) begin step(); if (down_req !== 1'b1) bad = 1'b1; end
    checks++; if (bad !== 1'b0) begin fails++; $display("FAIL pause_req_hold: got drop expected held high"); end
    down_ack = 1'b1; step(); down_ack = 1'b0;
    checks++; if (down_req !== 1'b0 || active !== 1'b1) begin fails++; $display("FAIL pause_ack: got down_req=%b active=%b expected 0/1", down_req, active); end
    bad = 1'b0;
    repeat (5) begin tick = 1'b1; step(); tick = 1'b0; if (down_req !== 1'b0) bad = 1'b1; end
    checks++; if (bad !== 1'b0) begin fails++; $display("FAIL pause_tick_ignored: got down_req expected none"); end
    pause = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (down_req !== 1'b1) begin fails++; $display("FAIL unpause_tick: got %b expected 1", down_req); end
    down_ack = 1'b1; step(); down_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    hard_drop = 1'b1; step(); hard_drop = 1'b0;
    repeat (4) begin
      down_ack = 1'b1; step(); down_ack = 1'b0;
      step();
    end
    checks++; if (down_req !== 1'b1 || drop_count !== 8'd4) begin fails++; $display("FAIL pre_reset: got down_req=%b drop_count=%0d expected 1/4", down_req, drop_count); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (down_req !== 1'b0 || drop_count !== 8'd0 || active !== 1'b0) begin
      fails++; $display("FAIL mid_reset: got down_req=%b drop_count=%0d active=%b expected 0/0/0", down_req, drop_count, active);
    end
    down_ack = 1'b1; step(); down_ack = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (down_req !== 1'b0 || active !== 1'b0 || drop_count !== 8'd0) begin
      fails++; $display("FAIL late_ack_ignored: got down_req=%b active=%b drop_count=%0d expected 0/0/0", down_req, active, drop_count);
    end
  endtask

  task automatic test_saturate();
    spawn();
    hard_drop = 1'b1; step(); hard_drop = 1'b0;
    for (int i = 0; i < 260; i++) begin
      down_ack = 1'b1; step(); down_ack = 1'b0;
      step();
    end
    checks++; if (drop_count !== 8'd255) begin fails++; $display("FAIL drop_saturate: got %0d expected 255", drop_count); end
    down_blocked = 1'b1; step(); down_blocked = 1'b0;
    checks++; if (lock_req !== 1'b1) begin fails++; $display("FAIL saturate_lock: got %b expected 1", lock_req); end
    finish_lock();
  endtask

  initial begin
    rst = 1'b1; pause = 1'b0; spawn_valid = 1'b0; tick = 1'b0; soft_drop = 1'b0;
    hard_drop = 1'b0; moved = 1'b0; down_ack = 1'b0; down_blocked = 1'b0; lock_ack = 1'b0;
    test_reset();
    test_gravity();
    test_soft();
    test_hard();
    test_lock_delay();
    test_pause();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
